// File: rtl/id_branch_ctrl.sv
// ID-stage branch/jump controller: stalls on unresolved source operands, then
// issues a registered one-cycle PC redirect and IF/ID flush for taken control flow.
module id_branch_ctrl #(
    parameter int unsigned CNT_W    = 16,
    parameter logic [4:0]  LINK_REG = 5'd31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic             id_jr,
    input  logic [2:0]       id_cmpctr,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             cmp_true,
    input  logic [31:0]      target,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             mem_memread,
    input  logic [4:0]       mem_rd,
    output logic             stall,
    output logic             flush_ifid,
    output logic             pc_redirect,
    output logic [31:0]      redirect_pc,
    output logic             link_we,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_REDIR
    } state_t;

    state_t            state_q, state_d;
    logic              wcnt_q, wcnt_d;
    logic [31:0]       redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;

    logic ctl, taken, need_rs, need_rt;
    logic ex_match, mem_match, haz2, haz1;

    assign ctl     = id_valid & (id_branch | id_jump);
    assign taken   = id_jump | (id_branch & cmp_true);
    assign need_rs = id_branch | (id_jump & id_jr);
    assign need_rt = id_branch & ((id_cmpctr == 3'b000) | (id_cmpctr == 3'b001));

    // Register 0 is hardwired, so a write to it can never create a hazard.
    assign ex_match  = (ex_rd != 5'd0) &
                       ((need_rs & (ex_rd == id_rs)) | (need_rt & (ex_rd == id_rt)));
    assign mem_match = (mem_rd != 5'd0) &
                       ((need_rs & (mem_rd == id_rs)) | (need_rt & (mem_rd == id_rt)));

    assign haz2 = ex_memread & ex_regwrite & ex_match;
    assign haz1 = (ex_regwrite & ~ex_memread & ex_match) | (mem_memread & mem_match);

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        redirect_pc_d = '0;
        taken_cnt_d   = taken_cnt_q;
        stall         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ctl && haz2) begin
                    state_d = S_WAIT;
                    wcnt_d  = 1'b1;
                    stall   = 1'b1;
                end else if (ctl && haz1) begin
                    state_d = S_WAIT;
                    wcnt_d  = 1'b0;
                    stall   = 1'b1;
                end else if (ctl && taken) begin
                    // Counter bumps on entry so it is already visible during the redirect cycle.
                    state_d       = S_REDIR;
                    redirect_pc_d = target;
                    if (taken_cnt_q != '1) begin
                        taken_cnt_d = taken_cnt_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (wcnt_q) begin
                    wcnt_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REDIR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wcnt_q        <= 1'b0;
            redirect_pc_q <= '0;
            taken_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            redirect_pc_q <= redirect_pc_d;
            taken_cnt_q   <= taken_cnt_d;
        end
    end

    assign pc_redirect = (state_q == S_REDIR);
    assign flush_ifid  = (state_q == S_REDIR);
    assign redirect_pc = redirect_pc_q;
    assign taken_cnt   = taken_cnt_q;

    // A link target of register 0 would be discarded anyway, so never request it.
    assign link_we = id_valid & (LINK_REG != 5'd0) &
                     ((id_branch & (id_cmpctr[2:1] == 2'b11)) | (id_jump & ~id_jr));

endmodule

// File: tb/tb_id_branch_ctrl.sv
// Directed bench for id_branch_ctrl: vector table for single-resolve cases plus
// hand-written hazard, reset and counter-saturation sequences.
module tb_id_branch_ctrl;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_branch, id_jump, id_jr, cmp_true;
    logic [2:0]  id_cmpctr;
    logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
    logic [31:0] target;
    logic        ex_regwrite, ex_memread, mem_memread;

    logic        stall, flush_ifid, pc_redirect, link_we;
    logic [31:0] redirect_pc;
    logic [15:0] taken_cnt;

    logic        s_stall, s_flush, s_redir, s_link;
    logic [31:0] s_pc;
    logic [1:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_branch_ctrl #(.CNT_W(16), .LINK_REG(5'd31)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_branch(id_branch),
        .id_jump(id_jump), .id_jr(id_jr), .id_cmpctr(id_cmpctr), .id_rs(id_rs),
        .id_rt(id_rt), .cmp_true(cmp_true), .target(target),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .mem_memread(mem_memread), .mem_rd(mem_rd), .stall(stall),
        .flush_ifid(flush_ifid), .pc_redirect(pc_redirect),
        .redirect_pc(redirect_pc), .link_we(link_we), .taken_cnt(taken_cnt)
    );

    id_branch_ctrl #(.CNT_W(2), .LINK_REG(5'd31)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_branch(id_branch),
        .id_jump(id_jump), .id_jr(id_jr), .id_cmpctr(id_cmpctr), .id_rs(id_rs),
        .id_rt(id_rt), .cmp_true(cmp_true), .target(target),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .mem_memread(mem_memread), .mem_rd(mem_rd), .stall(s_stall),
        .flush_ifid(s_flush), .pc_redirect(s_redir),
        .redirect_pc(s_pc), .link_we(s_link), .taken_cnt(s_cnt)
    );

    typedef struct {
        logic       valid, branch, jump, jr;
        logic [2:0] cmpctr;
        logic [4:0] rs, rt;
        logic       cmp;
        logic       exrw, exmr;
        logic [4:0] exrd;
        logic       mmr;
        logic [4:0] mrd;
        logic       e_stall, e_link, e_redir;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        id_valid = F; id_branch = F; id_jump = F; id_jr = F; cmp_true = F;
        id_cmpctr = 3'b000; id_rs = 5'd0; id_rt = 5'd0; target = 32'h0;
        ex_regwrite = F; ex_memread = F; ex_rd = 5'd0;
        mem_memread = F; mem_rd = 5'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = T;
        next_cycle();
        rst = F;
    endtask

    task automatic apply(input vec_t v);
        id_valid = v.valid; id_branch = v.branch; id_jump = v.jump; id_jr = v.jr;
        id_cmpctr = v.cmpctr; id_rs = v.rs; id_rt = v.rt; cmp_true = v.cmp;
        ex_regwrite = v.exrw; ex_memread = v.exmr; ex_rd = v.exrd;
        mem_memread = v.mmr; mem_rd = v.mrd;
    endtask

    task automatic set_jal(input logic [31:0] tgt);
        clear_inputs();
        id_valid = T; id_jump = T; target = tgt;
    endtask

    initial begin
        // valid br  jmp jr  cmpctr  rs     rt     cmp exrw exmr exrd   mmr mrd    stall link redir
        vecs[0]  = '{T, T, F, F, 3'b000, 5'd5, 5'd5, T, F, F, 5'd0,  F, 5'd0,  F, F, T}; // beq taken
        vecs[1]  = '{T, T, F, F, 3'b001, 5'd5, 5'd6, F, F, F, 5'd0,  F, 5'd0,  F, F, F}; // bne untaken
        vecs[2]  = '{T, F, T, T, 3'b000, 5'd8, 5'd0, F, T, T, 5'd8,  F, 5'd0,  T, F, F}; // jr, EX load
        vecs[3]  = '{T, T, F, F, 3'b000, 5'd2, 5'd9, T, T, F, 5'd9,  F, 5'd0,  T, F, F}; // beq rt, EX alu
        vecs[4]  = '{T, T, F, F, 3'b000, 5'd0, 5'd0, T, T, F, 5'd0,  F, 5'd0,  F, F, T}; // r0 no hazard
        vecs[5]  = '{T, T, F, F, 3'b111, 5'd3, 5'd0, F, F, F, 5'd0,  F, 5'd0,  F, T, F}; // bgezal untaken
        vecs[6]  = '{T, F, T, F, 3'b000, 5'd0, 5'd0, F, F, F, 5'd0,  F, 5'd0,  F, T, T}; // jal
        vecs[7]  = '{T, F, T, T, 3'b000, 5'd8, 5'd0, F, F, F, 5'd0,  F, 5'd0,  F, F, T}; // jr clean
        vecs[8]  = '{T, T, F, F, 3'b010, 5'd3, 5'd7, F, T, F, 5'd7,  F, 5'd0,  F, F, F}; // rs-only, rt ignored
        vecs[9]  = '{T, T, F, F, 3'b000, 5'd4, 5'd1, T, F, F, 5'd0,  T, 5'd4,  T, F, F}; // MEM load on rs
        vecs[10] = '{F, T, F, F, 3'b000, 5'd4, 5'd4, T, T, T, 5'd4,  F, 5'd0,  F, F, F}; // not valid
        vecs[11] = '{T, F, T, F, 3'b000, 5'd6, 5'd0, F, T, T, 5'd6,  F, 5'd0,  F, T, T}; // j ignores rs
        vecs[12] = '{T, F, T, T, 3'b000, 5'd8, 5'd0, F, F, T, 5'd8,  F, 5'd0,  F, F, T}; // load w/o regwrite

        clear_inputs();
        rst = T;
        next_cycle();
        next_cycle();
        rst = F;
        @(negedge clk);
        chk("reset_stall", {31'b0, stall}, 32'h0);
        chk("reset_flush", {31'b0, flush_ifid}, 32'h0);
        chk("reset_redirect", {31'b0, pc_redirect}, 32'h0);
        chk("reset_pc", redirect_pc, 32'h0);
        chk("reset_cnt", {16'b0, taken_cnt}, 32'h0);

        for (int i = 0; i < 13; i++) begin
            do_reset();
            apply(vecs[i]);
            target = 32'h0040_0040 + 32'(i * 4);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].e_stall});
            chk($sformatf("v%0d_link", i), {31'b0, link_we}, {31'b0, vecs[i].e_link});
            next_cycle();
            clear_inputs();
            @(negedge clk);
            chk($sformatf("v%0d_redir", i), {31'b0, pc_redirect}, {31'b0, vecs[i].e_redir});
            chk($sformatf("v%0d_flush", i), {31'b0, flush_ifid}, {31'b0, vecs[i].e_redir});
            chk($sformatf("v%0d_pc", i), redirect_pc,
                vecs[i].e_redir ? 32'h0040_0040 + 32'(i * 4) : 32'h0);
            chk($sformatf("v%0d_cnt", i), {16'b0, taken_cnt}, {31'b0, vecs[i].e_redir});
        end

        // Taken redirect is exactly one cycle wide.
        do_reset();
        apply(vecs[0]);
        target = 32'h0040_0040;
        next_cycle();
        clear_inputs();
        next_cycle();
        @(negedge clk);
        chk("post_redir_redirect", {31'b0, pc_redirect}, 32'h0);
        chk("post_redir_flush", {31'b0, flush_ifid}, 32'h0);
        chk("post_redir_pc", redirect_pc, 32'h0);
        chk("post_redir_stall", {31'b0, stall}, 32'h0);
        chk("post_redir_cnt", {16'b0, taken_cnt}, 32'h1);

        // Load-use hazard on jr: the load advances through EX, MEM, then retires.
        do_reset();
        apply(vecs[2]);
        target = 32'h0000_1234;
        @(negedge clk);
        chk("h2_c0_stall", {31'b0, stall}, 32'h1);
        next_cycle();
        ex_regwrite = F; ex_memread = F; ex_rd = 5'd0;
        mem_memread = T; mem_rd = 5'd8;
        @(negedge clk);
        chk("h2_c1_stall", {31'b0, stall}, 32'h1);
        chk("h2_c1_redir", {31'b0, pc_redirect}, 32'h0);
        next_cycle();
        mem_memread = F; mem_rd = 5'd0;
        @(negedge clk);
        chk("h2_c2_stall", {31'b0, stall}, 32'h1);
        next_cycle();
        @(negedge clk);
        chk("h2_c3_stall", {31'b0, stall}, 32'h0);
        chk("h2_c3_redir", {31'b0, pc_redirect}, 32'h0);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        chk("h2_c4_redir", {31'b0, pc_redirect}, 32'h1);
        chk("h2_c4_pc", redirect_pc, 32'h0000_1234);
        chk("h2_c4_stall", {31'b0, stall}, 32'h0);

        // ALU hazard on beq rt: one wait cycle, then redirect.
        do_reset();
        apply(vecs[3]);
        target = 32'h0000_5678;
        @(negedge clk);
        chk("h1_c0_stall", {31'b0, stall}, 32'h1);
        next_cycle();
        ex_regwrite = F; ex_rd = 5'd0;
        @(negedge clk);
        chk("h1_c1_stall", {31'b0, stall}, 32'h1);
        next_cycle();
        @(negedge clk);
        chk("h1_c2_stall", {31'b0, stall}, 32'h0);
        chk("h1_c2_redir", {31'b0, pc_redirect}, 32'h0);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        chk("h1_c3_redir", {31'b0, pc_redirect}, 32'h1);
        chk("h1_c3_pc", redirect_pc, 32'h0000_5678);

        // Reset while waiting aborts the sequence and clears the counter.
        do_reset();
        set_jal(32'h0000_0100);
        next_cycle();
        apply(vecs[2]);
        next_cycle();
        @(negedge clk);
        chk("rstwait_pre_stall", {31'b0, stall}, 32'h1);
        chk("rstwait_pre_cnt", {16'b0, taken_cnt}, 32'h1);
        clear_inputs();
        rst = T;
        next_cycle();
        rst = F;
        @(negedge clk);
        chk("rstwait_stall", {31'b0, stall}, 32'h0);
        chk("rstwait_cnt", {16'b0, taken_cnt}, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("rstwait_redir", {31'b0, pc_redirect}, 32'h0);

        // Five taken jumps: 2-bit counter saturates, 16-bit counter keeps counting.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_jal(32'h0000_0200 + 32'(k * 4));
            next_cycle();
            clear_inputs();
            next_cycle();
        end
        @(negedge clk);
        chk("sat_cnt2", {30'b0, s_cnt}, 32'h3);
        chk("sat_cnt16", {16'b0, taken_cnt}, 32'h5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
